// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory boot path.
//   XLEN          : instruction word width (32)
//   CNT_W         : width of word-count / word-index arithmetic (17), wide
//                   enough to hold 2^ADDR_W for every ADDR_W up to 16
//   boot_state_e  : boot loader FSM states
//   len_ok()      : legal-length test for the stream header
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 17;

  typedef enum logic [2:0] {
    LEN0  = 3'd0,
    LEN1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } boot_state_e;

  // A header is legal when 1 <= n <= 2^addr_w (the memory depth).
  function automatic logic len_ok(input logic [CNT_W-1:0] n,
                                  input int unsigned      addr_w);
    logic [CNT_W-1:0] depth;
    depth = CNT_W'(1) << addr_w;
    return (n != '0) && (n <= depth);
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler.
//   clock, rst  : system clock, asynchronous active-high reset
//   byte_en     : a byte is consumed this cycle
//   byte_data   : the consumed byte
//   word        : registered assembly register (full word once complete)
//   word_done   : combinational pulse on the fourth byte of a word
module word_assembler
  import riscv_pkg::*;
(
  input  logic            clock,
  input  logic            rst,
  input  logic            byte_en,
  input  logic [7:0]      byte_data,
  output logic [XLEN-1:0] word,
  output logic            word_done
);

  logic [1:0]      idx_q,  idx_d;
  logic [XLEN-1:0] word_q, word_d;

  // Bytes shift in from the top, so after four bytes the first one
  // lands in bits 7:0. No clear is needed between words: four shifts
  // replace every bit.
  always_comb begin
    idx_d     = idx_q;
    word_d    = word_q;
    word_done = 1'b0;
    if (byte_en) begin
      word_d    = {byte_data, word_q[XLEN-1:8]};
      idx_d     = idx_q + 2'd1;
      word_done = (idx_q == 2'd3);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader. Receives a byte stream
// (2-byte LE word count N, then N LE 32-bit words), writes the words to
// instruction memory from address 0, and releases the core reset when done.
//   clock, rst             : system clock, asynchronous active-high reset
//   byte_valid/byte_data   : upstream byte source
//   byte_ready             : byte accepted when byte_valid & byte_ready
//   imem_we/addr/wdata     : instruction-memory write port
//   cpu_rst                : core reset, held until the image is loaded
//   load_done              : image loaded, core released
//   load_err               : illegal length header (N==0 or N>depth)
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  boot_state_e      state_q, state_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] word_idx_q, word_idx_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             load_done_q, load_done_d;
  logic             load_err_q, load_err_d;

  logic             accept;
  logic             asm_en;
  logic [XLEN-1:0]  asm_word;
  logic             word_done;
  logic [CNT_W-1:0] hdr_count;

  // byte_ready is forced low while rst is held, not just after the edge.
  assign byte_ready = (state_q == LEN0 || state_q == LEN1 || state_q == DATA)
                      && !rst;
  assign accept     = byte_valid && byte_ready;
  // Kept outside the FSM process so word_done -> state_d is a plain
  // forward path with no combinational feedback.
  assign asm_en     = accept && (state_q == DATA);
  assign hdr_count  = {1'b0, byte_data, len_lo_q};

  word_assembler u_word_assembler (
    .clock     (clock),
    .rst       (rst),
    .byte_en   (asm_en),
    .byte_data (byte_data),
    .word      (asm_word),
    .word_done (word_done)
  );

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;

    case (state_q)
      LEN0: begin
        if (accept) begin
          len_lo_d = byte_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          count_d    = hdr_count;
          word_idx_d = '0;
          state_d    = len_ok(hdr_count, ADDR_W) ? DATA : ERR;
        end
      end
      DATA: begin
        if (word_done) state_d = WRITE;
      end
      WRITE: begin
        word_idx_d = word_idx_q + CNT_W'(1);
        state_d    = (word_idx_q == count_q - CNT_W'(1)) ? DONE : DATA;
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = LEN0;
    endcase

    // Status outputs are registered from the next state so they change
    // on the same edge as the state itself.
    cpu_rst_d   = (state_d != DONE);
    load_done_d = (state_d == DONE);
    load_err_d  = (state_d == ERR);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= LEN0;
      len_lo_q    <= '0;
      count_q     <= '0;
      word_idx_q  <= '0;
      cpu_rst_q   <= 1'b1;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      cpu_rst_q   <= cpu_rst_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  assign imem_we    = (state_q == WRITE);
  assign imem_addr  = word_idx_q[ADDR_W-1:0];
  assign imem_wdata = asm_word;
  assign cpu_rst    = cpu_rst_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule
